// File: rtl/fp_divider.sv
// Single-precision floating-point divider.
// Uses a restoring mantissa divide that produces one quotient bit per cycle.
// Rounding is by truncation. Special operands are resolved when the request is accepted.
module fp_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, PRENORM, DIVIDE, NORMALISE, DONE} state_t;

  state_t             state_q, state_d;
  logic [23:0]        mantA_q, mantA_d;
  logic [23:0]        mantB_q, mantB_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [24:0]        rem_q, rem_d;
  logic [24:0]        quot_q, quot_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic [31:0]        out_q, out_d;

  // Unpack the input operands. A zero exponent field is treated as exponent 1 with no hidden bit.
  logic               hidA, hidB;
  logic signed [9:0]  expA, expB, expWork;
  logic               aExpMax, bExpMax, aZero, bZero;
  assign hidA    = |A[30:23];
  assign hidB    = |B[30:23];
  assign expA    = hidA ? {2'b00, A[30:23]} : 10'sd1;
  assign expB    = hidB ? {2'b00, B[30:23]} : 10'sd1;
  assign expWork = expA - expB + 10'sd127;
  assign aExpMax = &A[30:23];
  assign bExpMax = &B[30:23];
  assign aZero   = ~|A[30:0];
  assign bZero   = ~|B[30:0];

  // One pre-normalisation step. A dividend shift lowers the quotient exponent.
  // A divisor shift raises it.
  logic [23:0]        preA, preB;
  logic signed [9:0]  preExp;
  assign preA   = mantA_q[23] ? mantA_q : {mantA_q[22:0], 1'b0};
  assign preB   = mantB_q[23] ? mantB_q : {mantB_q[22:0], 1'b0};
  assign preExp = exp_q - {9'd0, ~mantA_q[23]} + {9'd0, ~mantB_q[23]};

  // One restoring-division step.
  logic               divGe;
  logic [24:0]        divDiff;
  assign divGe   = rem_q >= {1'b0, mantB_q};
  assign divDiff = divGe ? (rem_q - {1'b0, mantB_q}) : rem_q;

  // Quotient normalisation. The quotient lies in [0.5, 2), so at most one bit position needs correcting.
  logic signed [9:0]  normExp;
  logic [22:0]        normMant;
  assign normExp  = quot_q[24] ? exp_q : (exp_q - 10'sd1);
  assign normMant = quot_q[24] ? quot_q[23:1] : quot_q[22:0];

  // Register all state. Reset is synchronous and takes priority over every handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mantA_q <= '0;
      mantB_q <= '0;
      exp_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      mantA_q <= mantA_d;
      mantB_q <= mantB_d;
      exp_q   <= exp_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      out_q   <= out_d;
    end
  end

  // Compute the next state and datapath values for each FSM phase.
  always_comb begin
    state_d = state_q;
    mantA_d = mantA_q;
    mantB_d = mantB_q;
    exp_d   = exp_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = A[31] ^ B[31];
          mantA_d = {hidA, A[22:0]};
          mantB_d = {hidB, B[22:0]};
          exp_d   = expWork;
          rem_d   = {1'b0, hidA, A[22:0]};
          quot_d  = '0;
          cnt_d   = '0;
          if (aExpMax || bExpMax || (aZero && bZero)) begin
            out_d   = 32'h7FC0_0000;
            state_d = DONE;
          end else if (bZero) begin
            out_d   = {A[31] ^ B[31], 8'hFF, 23'd0};
            state_d = DONE;
          end else if (aZero) begin
            out_d   = {A[31] ^ B[31], 31'd0};
            state_d = DONE;
          end else if (hidA && hidB) begin
            state_d = DIVIDE;
          end else begin
            state_d = PRENORM;
          end
        end
      end
      PRENORM: begin
        mantA_d = preA;
        mantB_d = preB;
        exp_d   = preExp;
        rem_d   = {1'b0, preA};
        if (preA[23] && preB[23]) begin
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        quot_d = {quot_q[23:0], divGe};
        rem_d  = {divDiff[23:0], 1'b0};
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd24) begin
          state_d = NORMALISE;
        end
      end
      NORMALISE: begin
        if (normExp >= 10'sd255) begin
          out_d = {sign_q, 8'hFF, 23'd0};
        end else if (normExp <= 10'sd0) begin
          out_d = {sign_q, 31'd0};
        end else begin
          out_d = {sign_q, normExp[7:0], normMant};
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;

endmodule

// File: tb/tb_fp_divider.sv
// Scoreboard bench for fp_divider.
// The stimulus process queues each expected result together with its latency and backpressure hold.
// The monitor process pops and checks an entry whenever out_valid is seen.
module tb_fp_divider;

  logic        clk;
  logic        rst;
  logic [31:0] A, B;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  typedef struct {
    logic [31:0] value;
    int          lat;
    int          edgeNo;
    int          hold;
  } exp_t;

  exp_t sb[$];
  exp_t item;
  int   checks = 0;
  int   errors = 0;
  int   cycleCount = 0;

  fp_divider dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // Free-running clock with a 10-time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges so that latencies can be measured.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Global watchdog so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Wait for in_ready, issue one request, and optionally queue its expected result.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expOut,
                               input int expLat, input int hold, input bit push);
    int waitCnt;
    waitCnt = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && waitCnt < 300) begin
      @(negedge clk);
      waitCnt++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL inReadyTimeout: got in_ready=%b, expected 1 within 300 cycles", in_ready);
      return;
    end
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = 32'hDEAD_BEEF;
    B = 32'h1234_5678;
    if (push) sb.push_back('{expOut, expLat, cycleCount, hold});
    checkOutput("busyAfterAccept", {31'd0, busy}, 32'd1);
  endtask

  // Monitor: compare each result against the scoreboard, apply backpressure, then check the release.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedValid: got out_valid=1 with out=0x%08h, expected no result", out);
          out_ready = 1'b1;
          @(negedge clk);
          out_ready = 1'b0;
        end else begin
          item = sb.pop_front();
          checkOutput("result", out, item.value);
          checkOutput("latency", cycleCount - item.edgeNo + 1, item.lat);
          for (int i = 0; i < item.hold; i++) begin
            @(negedge clk);
            checkOutput("holdValid", {31'd0, out_valid}, 32'd1);
            checkOutput("holdOut", out, item.value);
            checkOutput("holdInReady", {31'd0, in_ready}, 32'd0);
          end
          out_ready = 1'b1;
          @(negedge clk);
          out_ready = 1'b0;
          checkOutput("releaseValid", {31'd0, out_valid}, 32'd0);
          checkOutput("releaseInReady", {31'd0, in_ready}, 32'd1);
        end
      end
    end
  end

  // Main directed sequence.
  initial begin
    int sawValid;
    int drain;
    rst = 1'b1;
    in_valid = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetInReady", {31'd0, in_ready}, 32'd1);
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    checkOutput("resetValid", {31'd0, out_valid}, 32'd0);
    checkOutput("resetOut", out, 32'd0);
    rst = 1'b0;

    // Columns: dividend, divisor, expected quotient, latency, hold cycles, push to scoreboard.
    applyStimulus(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 27, 0, 1);
    applyStimulus(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 27, 10, 1);
    applyStimulus(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1, 0, 1);
    applyStimulus(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1, 0, 1);
    applyStimulus(32'h0040_0000, 32'h0080_0000, 32'h3F00_0000, 28, 0, 1);
    applyStimulus(32'h3F80_0000, 32'h0040_0000, 32'h7F00_0000, 28, 0, 1);
    applyStimulus(32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 1, 0, 1);
    applyStimulus(32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 1, 0, 1);
    applyStimulus(32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 27, 0, 1);
    applyStimulus(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 27, 0, 1);
    applyStimulus(32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 27, 0, 1);

    // Abort 6.0/2.0 ten cycles into DIVIDE. No result may appear for it.
    applyStimulus(32'h40C0_0000, 32'h4000_0000, 32'h0, 0, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abortInReady", {31'd0, in_ready}, 32'd1);
    checkOutput("abortBusy", {31'd0, busy}, 32'd0);
    checkOutput("abortValid", {31'd0, out_valid}, 32'd0);
    checkOutput("abortOut", out, 32'd0);
    sawValid = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid === 1'b1) sawValid++;
    end
    checkOutput("abortNoValid", sawValid, 32'd0);

    applyStimulus(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 27, 0, 1);

    drain = 0;
    while ((sb.size() != 0 || in_ready !== 1'b1) && drain < 300) begin
      @(negedge clk);
      drain++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drainTimeout: got %0d pending results, expected 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_divider.md
FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001 The block SHALL have no parameters; the operand and result format SHALL be fixed at IEEE-754 single precision (32 bits).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port A, input, 32 bits: dividend; sampled only on an accepted request.
REQ-005 The block SHALL have port B, input, 32 bits: divisor; sampled only on an accepted request.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the requester presents A and B.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-008 The block SHALL have port out, output, 32 bits: the quotient A/B.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out holds a result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 States SHALL be IDLE, PRENORM, DIVIDE, NORMALISE and DONE; in_ready SHALL be 1 only in IDLE.
REQ-013 A request SHALL be accepted when in_valid and in_ready are both 1 on a clock edge; A and B SHALL be latched on that edge.
REQ-014 Operand unpack SHALL work as follows: an exponent field of 0 gives an exponent of 1 and hidden bit 0; any other exponent gives that exponent and hidden bit 1; the mantissa is 24 bits.
REQ-015 Result sign SHALL be A[31] XOR B[31] for every result, including infinities and zeros; a NaN result SHALL use the fixed encoding 0x7FC00000.
REQ-016 Special cases SHALL be decided on the acceptance edge and SHALL go straight to DONE, giving out_valid on the next cycle.
- Either exponent field 0xFF -> 0x7FC00000.
- Both operands zero -> 0x7FC00000.
- B zero, A non-zero -> signed infinity (exponent 0xFF, mantissa 0).
- A zero, B non-zero -> signed zero.
REQ-017 PRENORM SHALL shift any mantissa with bit 23 = 0 left by one bit per cycle and decrement its 10-bit signed exponent, until bit 23 = 1 on both mantissas; it SHALL take zero cycles for normal operands.
REQ-018 The working exponent SHALL be the 10-bit signed value eA - eB + 127.
REQ-019 DIVIDE SHALL be a restoring division over exactly 25 cycles, one quotient bit per cycle, MSB first.
- The 25-bit remainder starts equal to mA.
- Each cycle: if rem >= mB, the quotient bit is 1 and rem = rem - mB; then rem is shifted left by 1.
REQ-020 NORMALISE SHALL take 1 cycle.
- If q[24] = 1: mantissa = q[23:1].
- Otherwise: mantissa = q[22:0] and exponent is decremented by 1.
- Rounding SHALL be truncation; the remainder SHALL be discarded.
REQ-021 After NORMALISE, an exponent >= 255 SHALL give signed infinity, and an exponent <= 0 SHALL flush to signed zero.
REQ-022 Latency for normal operands SHALL be fixed: out_valid rises 27 cycles after the acceptance edge (25 DIVIDE + 1 NORMALISE + 1 to DONE); each PRENORM shift adds 1 cycle.
REQ-023 In DONE, out and out_valid SHALL hold stable until out_ready = 1.
- The edge with out_ready = 1 SHALL return the block to IDLE.
- out_valid SHALL drop on the following cycle.
- in_ready SHALL rise on the following cycle; there is no same-cycle reaccept.
REQ-024 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE.

Reset
REQ-025 While rst = 1 at a clock edge, the next state SHALL be IDLE with out = 0, out_valid = 0, in_ready = 1 and busy = 0; rst SHALL take priority over all handshakes.
REQ-026 Reset asserted mid-operation (PRENORM, DIVIDE, NORMALISE or DONE) SHALL abort the operation; no out_valid pulse SHALL appear for the aborted request.

Verification
REQ-027 Basic divide: A=0x40C00000, B=0x40000000 (6.0/2.0) -> out=0x40400000, with out_valid exactly 27 cycles after acceptance.
REQ-028 Truncation: A=0x3F800000, B=0x40400000 (1.0/3.0) -> out=0x3EAAAAAA.
REQ-029 Special cases, each with out_valid 1 cycle after acceptance:
- A=0xBF800000, B=0x00000000 -> 0xFF800000.
- A=0x00000000, B=0x00000000 -> 0x7FC00000.
REQ-030 Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out stable, in_ready=0 throughout; then out_ready=1 for one edge -> out_valid=0 and in_ready=1 on the next cycle.
REQ-031 Denormal dividend: A=0x00400000, B=0x00800000 -> out=0x3F000000, with latency 28 cycles (1 PRENORM shift).
REQ-032 Reset mid-operation: assert rst 10 cycles into DIVIDE -> IDLE next cycle, out_valid never pulses; a new request 6.0/2.0 then completes normally.
